ibex_vector_cfg_unit: RTL and testbench

IBEX_VECTOR_CFG_UNIT -- requirements
Module: ibex_vector_cfg_unit

---
 rtl/ibex_vector_cfg_unit.sv | 215 +++++++++++++++++++++
 tb/tb_ibex_vector_cfg_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_vector_cfg_unit.sv
// ibex_vector_cfg_unit: vsetvl(i) sequencer (IDLE -> CALC -> COMMIT) plus the vector CSR file.
// Build option: define IBEX_VEC_FRAC_LMUL_EN to accept fractional LMUL encodings (vlmul 5/6/7).
module ibex_vector_cfg_unit #(
    parameter int unsigned VLEN = 128,
    parameter int unsigned ELEN = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [31:0] cfg_avl_i,
    input  logic [31:0] cfg_vtype_i,
    input  logic [1:0]  cfg_mode_i,
    output logic        res_valid_o,
    output logic [31:0] res_vl_o,
    input  logic [11:0] csr_addr_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        vxsat_set_i,
    output logic [31:0] vl_o,
    output logic [2:0]  vsew_o,
    output logic [2:0]  vlmul_o,
    output logic        vill_o,
    output logic [31:0] vlmax_o,
    output logic [31:0] vstart_o,
    output logic [1:0]  vxrm_o
);
    localparam int unsigned VSTART_W   = $clog2(VLEN);
    localparam logic [31:0] VTYPE_VILL = 32'h8000_0000;
    localparam logic [31:0] VLENB      = 32'(VLEN / 8);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    // VLMAX = (VLEN/SEW)*LMUL; fractional encodings shift right by 3/2/1 (wrap of 0 - vlmul).
    function automatic logic [31:0] vlmax_of(input logic [2:0] sew_enc, input logic [2:0] lmul_enc);
        logic [31:0] base;
        logic [31:0] res;
        base = VLENB >> sew_enc;
        case (lmul_enc)
            3'd0, 3'd1, 3'd2, 3'd3: res = base << lmul_enc;
`ifdef IBEX_VEC_FRAC_LMUL_EN
            3'd5, 3'd6, 3'd7:       res = base >> (3'd0 - lmul_enc);
`endif
            default:                res = '0;
        endcase
        return res;
    endfunction

    function automatic logic vill_of(input logic [31:0] vtype);
        logic [2:0]  sew_enc;
        logic [2:0]  lmul_enc;
        logic [31:0] sew;
        logic        bad_lmul;
        sew_enc  = vtype[5:3];
        lmul_enc = vtype[2:0];
        sew      = 32'd8 << sew_enc;
`ifdef IBEX_VEC_FRAC_LMUL_EN
        bad_lmul = (lmul_enc == 3'd4) ||
                   (lmul_enc[2] && ((sew << (3'd0 - lmul_enc)) > 32'(ELEN)));
`else
        bad_lmul = lmul_enc[2];
`endif
        return vtype[31] || (vtype[30:8] != '0) || (sew_enc >= 3'd3) ||
               (sew > 32'(ELEN)) || bad_lmul || (vlmax_of(sew_enc, lmul_enc) == '0);
    endfunction

    logic [1:0]          state_q;
    logic [31:0]         req_avl_q;
    logic [31:0]         req_vtype_q;
    logic [1:0]          req_mode_q;
    logic                calc_vill_q;
    logic [31:0]         calc_vl_q;
    logic [31:0]         vl_q;
    logic [31:0]         vtype_q;
    logic [VSTART_W-1:0] vstart_q;
    logic                vxsat_q;
    logic [1:0]          vxrm_q;

    logic                req_vill;
    logic [31:0]         req_vlmax;
    logic [31:0]         req_vl;
    logic                commit;
    logic                csr_wr;
    logic                vxsat_nxt;
    logic                unused_wdata;

    assign commit       = (state_q == COMMIT);
    assign csr_wr       = csr_we_i && !csr_illegal_o;
    assign unused_wdata = ^csr_wdata_i[31:VSTART_W];

    always_comb begin
        req_vill  = vill_of(req_vtype_q);
        req_vlmax = vlmax_of(req_vtype_q[5:3], req_vtype_q[2:0]);
        case (req_mode_q)
            2'd1:    req_vl = req_vlmax;
            2'd2:    req_vl = (vl_q < req_vlmax) ? vl_q : req_vlmax;
            default: req_vl = (req_avl_q < req_vlmax) ? req_avl_q : req_vlmax;
        endcase
        if (req_vill) begin
            req_vl = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            req_avl_q   <= '0;
            req_vtype_q <= '0;
            req_mode_q  <= '0;
            calc_vill_q <= 1'b0;
            calc_vl_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        req_avl_q   <= cfg_avl_i;
                        req_vtype_q <= cfg_vtype_i;
                        req_mode_q  <= cfg_mode_i;
                        state_q     <= CALC;
                    end
                end
                CALC: begin
                    calc_vill_q <= req_vill;
                    calc_vl_q   <= req_vl;
                    state_q     <= COMMIT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // vl and vtype change only on commit; CSR writes to them are rejected as illegal.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vl_q    <= '0;
            vtype_q <= VTYPE_VILL;
        end else if (commit) begin
            vl_q    <= calc_vl_q;
            vtype_q <= calc_vill_q ? VTYPE_VILL : req_vtype_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vstart_q <= '0;
        end else if (commit) begin
            vstart_q <= '0;
        end else if (csr_wr && (csr_addr_i == 12'h008)) begin
            vstart_q <= csr_wdata_i[VSTART_W-1:0];
        end
    end

    // A datapath saturation event wins over a same-cycle software clear.
    always_comb begin
        vxsat_nxt = vxsat_q;
        if (csr_wr && ((csr_addr_i == 12'h009) || (csr_addr_i == 12'h00F))) begin
            vxsat_nxt = csr_wdata_i[0];
        end
        vxsat_nxt = vxsat_nxt | vxsat_set_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vxsat_q <= 1'b0;
            vxrm_q  <= 2'd0;
        end else begin
            vxsat_q <= vxsat_nxt;
            if (csr_wr && (csr_addr_i == 12'h00A)) begin
                vxrm_q <= csr_wdata_i[1:0];
            end else if (csr_wr && (csr_addr_i == 12'h00F)) begin
                vxrm_q <= csr_wdata_i[2:1];
            end
        end
    end

    always_comb begin
        csr_rdata_o   = '0;
        csr_illegal_o = 1'b0;
        case (csr_addr_i)
            12'h008: csr_rdata_o = vstart_o;
            12'h009: csr_rdata_o = {31'd0, vxsat_q};
            12'h00A: csr_rdata_o = {30'd0, vxrm_q};
            12'h00F: csr_rdata_o = {29'd0, vxrm_q, vxsat_q};
            12'hC20: begin
                csr_rdata_o   = vl_q;
                csr_illegal_o = csr_we_i;
            end
            12'hC21: begin
                csr_rdata_o   = vtype_q;
                csr_illegal_o = csr_we_i;
            end
            12'hC22: begin
                csr_rdata_o   = VLENB;
                csr_illegal_o = csr_we_i;
            end
            default: csr_illegal_o = 1'b1;
        endcase
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign res_valid_o = commit;
    assign res_vl_o    = commit ? calc_vl_q : '0;
    assign vl_o        = vl_q;
    assign vsew_o      = vtype_q[5:3];
    assign vlmul_o     = vtype_q[2:0];
    assign vill_o      = vtype_q[31];
    assign vlmax_o     = vill_o ? '0 : vlmax_of(vtype_q[5:3], vtype_q[2:0]);
    assign vstart_o    = {{(32 - VSTART_W){1'b0}}, vstart_q};
    assign vxrm_o      = vxrm_q;

endmodule

// File: tb/tb_ibex_vector_cfg_unit.sv
// Self-checking bench for ibex_vector_cfg_unit: random traffic against an architectural model.
// Honours IBEX_VEC_FRAC_LMUL_EN the same way the design does.
`timescale 1ns/1ps
module tb_ibex_vector_cfg_unit;
    localparam int unsigned VLEN = 128;
    localparam int unsigned ELEN = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_avl = '0;
    logic [31:0] cfg_vtype = '0;
    logic [1:0]  cfg_mode = '0;
    logic        res_valid;
    logic [31:0] res_vl;
    logic [11:0] csr_addr = 12'hC20;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        vxsat_set = 1'b0;
    logic [31:0] vl;
    logic [2:0]  vsew;
    logic [2:0]  vlmul;
    logic        vill;
    logic [31:0] vlmax;
    logic [31:0] vstart;
    logic [1:0]  vxrm;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Architectural model state: what software would observe, plus the one outstanding request.
    logic [31:0] m_vl = '0;
    logic [31:0] m_vtype = 32'h8000_0000;
    logic [31:0] m_vstart = '0;
    logic        m_vxsat = 1'b0;
    logic [1:0]  m_vxrm = '0;
    bit          m_pending = 1'b0;
    int unsigned m_acc_cyc = 0;
    logic [31:0] m_avl = '0;
    logic [31:0] m_req_vtype = '0;
    logic [1:0]  m_mode = '0;
    int unsigned cyc = 0;

    ibex_vector_cfg_unit #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_avl_i(cfg_avl), .cfg_vtype_i(cfg_vtype), .cfg_mode_i(cfg_mode),
        .res_valid_o(res_valid), .res_vl_o(res_vl),
        .csr_addr_i(csr_addr), .csr_we_i(csr_we), .csr_wdata_i(csr_wdata),
        .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
        .vxsat_set_i(vxsat_set),
        .vl_o(vl), .vsew_o(vsew), .vlmul_o(vlmul), .vill_o(vill),
        .vlmax_o(vlmax), .vstart_o(vstart), .vxrm_o(vxrm)
    );

    always #5 clk = ~clk;

    function automatic bit lmul_supported(int unsigned lm);
        if (lm <= 3) return 1'b1;
`ifdef IBEX_VEC_FRAC_LMUL_EN
        return lm != 4;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned lmul_num(int unsigned lm);
        return (lm <= 3) ? (1 << lm) : 1;
    endfunction

    function automatic int unsigned lmul_den(int unsigned lm);
        case (lm)
            5: return 8;
            6: return 4;
            7: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] ref_vlmax(logic [31:0] vt);
        int unsigned sew;
        int unsigned lm;
        sew = 8 * (1 << vt[5:3]);
        lm  = vt[2:0];
        if (!lmul_supported(lm)) return 0;
        if (lmul_den(lm) == 1) return (VLEN / sew) * lmul_num(lm);
        return VLEN / (sew * lmul_den(lm));
    endfunction

    function automatic bit ref_vill(logic [31:0] vt);
        int unsigned sew;
        int unsigned lm;
        sew = 8 * (1 << vt[5:3]);
        lm  = vt[2:0];
        if (vt[31] || (vt[30:8] != 0) || (vt[5:3] >= 3)) return 1'b1;
        if (!lmul_supported(lm)) return 1'b1;
        if (sew * lmul_den(lm) > ELEN * lmul_num(lm)) return 1'b1;
        return ref_vlmax(vt) == 0;
    endfunction

    function automatic logic [31:0] ref_vl(logic [1:0] mode, logic [31:0] avl, logic [31:0] vt, logic [31:0] cur);
        logic [31:0] vm;
        if (ref_vill(vt)) return 0;
        vm = ref_vlmax(vt);
        if (mode == 2'd1) return vm;
        if (mode == 2'd2) return (cur < vm) ? cur : vm;
        return (avl < vm) ? avl : vm;
    endfunction

    function automatic bit ref_illegal(logic [11:0] a, bit we);
        case (a)
            12'h008, 12'h009, 12'h00A, 12'h00F: return 1'b0;
            12'hC20, 12'hC21, 12'hC22:          return we;
            default:                            return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(logic [11:0] a);
        case (a)
            12'h008: return m_vstart;
            12'h009: return 32'(m_vxsat);
            12'h00A: return 32'(m_vxrm);
            12'h00F: return 32'(m_vxrm) * 2 + 32'(m_vxsat);
            12'hC20: return m_vl;
            12'hC21: return m_vtype;
            12'hC22: return VLEN / 8;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic modelStep();
        bit ready_now;
        bit did_commit;
        if (!rstn) begin
            m_vl = '0; m_vtype = 32'h8000_0000; m_vstart = '0;
            m_vxsat = 1'b0; m_vxrm = '0; m_pending = 1'b0;
            return;
        end
        ready_now  = !m_pending;
        did_commit = 1'b0;
        if (m_pending && cyc == m_acc_cyc + 2) begin
            m_vl       = ref_vl(m_mode, m_avl, m_req_vtype, m_vl);
            m_vtype    = ref_vill(m_req_vtype) ? 32'h8000_0000 : m_req_vtype;
            m_vstart   = '0;
            m_pending  = 1'b0;
            did_commit = 1'b1;
        end
        if (csr_we && !ref_illegal(csr_addr, 1'b1)) begin
            case (csr_addr)
                12'h008: if (!did_commit) m_vstart = csr_wdata % VLEN;
                12'h009: m_vxsat = csr_wdata[0];
                12'h00A: m_vxrm = csr_wdata[1:0];
                12'h00F: begin
                    m_vxrm  = csr_wdata[2:1];
                    m_vxsat = csr_wdata[0];
                end
                default: ;
            endcase
        end
        m_vxsat = m_vxsat | vxsat_set;
        if (cfg_valid && ready_now) begin
            m_pending   = 1'b1;
            m_acc_cyc   = cyc;
            m_avl       = cfg_avl;
            m_req_vtype = cfg_vtype;
            m_mode      = cfg_mode;
        end
        cyc++;
    endtask

    task automatic checkAll();
        bit exp_valid;
        exp_valid = m_pending && (cyc == m_acc_cyc + 2);
        checkOutput("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
        checkOutput("res_valid", 32'(res_valid), 32'(exp_valid));
        if (exp_valid) checkOutput("res_vl", res_vl, ref_vl(m_mode, m_avl, m_req_vtype, m_vl));
        checkOutput("vl", vl, m_vl);
        checkOutput("vill", 32'(vill), 32'(m_vtype[31]));
        checkOutput("vsew", 32'(vsew), 32'(m_vtype[5:3]));
        checkOutput("vlmul", 32'(vlmul), 32'(m_vtype[2:0]));
        checkOutput("vlmax", vlmax, m_vtype[31] ? 32'd0 : ref_vlmax(m_vtype));
        checkOutput("vstart", vstart, m_vstart);
        checkOutput("vxrm", 32'(vxrm), 32'(m_vxrm));
        checkOutput("csr_illegal", 32'(csr_illegal), 32'(ref_illegal(csr_addr, csr_we)));
        if (!ref_illegal(csr_addr, 1'b0)) checkOutput("csr_rdata", csr_rdata, ref_read(csr_addr));
    endtask

    initial forever begin
        @(posedge clk or negedge rstn);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (check_en) checkAll();
    end

    task automatic applyStimulus(bit v, logic [31:0] avl, logic [31:0] vt, logic [1:0] mode,
                                 logic [11:0] addr, bit we, logic [31:0] wd, bit sat);
        cfg_valid = v; cfg_avl = avl; cfg_vtype = vt; cfg_mode = mode;
        csr_addr = addr; csr_we = we; csr_wdata = wd; vxsat_set = sat;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) applyStimulus(1'b0, '0, '0, 2'd0, 12'hC20, 1'b0, '0, 1'b0);
    endtask

    task automatic readCsr(logic [11:0] addr, logic [31:0] exp, string name);
        csr_addr = addr;
        csr_we   = 1'b0;
        #1;
        checkOutput(name, csr_rdata, exp);
    endtask

    logic [11:0] addr_pool [8] = '{12'h008, 12'h009, 12'h00A, 12'h00F, 12'hC20, 12'hC21, 12'hC22, 12'h123};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        check_en = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_vill", 32'(vill), 32'd1);
        checkOutput("rst_vl", vl, 32'd0);
        readCsr(12'hC21, 32'h8000_0000, "rst_vtype");
        idle(1);

        // vsew=8, LMUL=2, AVL=100 on VLEN=128
        applyStimulus(1'b1, 32'd100, 32'h0000_0001, 2'd0, 12'hC20, 1'b0, '0, 1'b0);
        checkOutput("calc_ready", 32'(cfg_ready), 32'd0);
        checkOutput("calc_res_valid", 32'(res_valid), 32'd0);
        idle(1);
        checkOutput("commit_res_valid", 32'(res_valid), 32'd1);
        checkOutput("commit_res_vl", res_vl, 32'd32);
        idle(1);
        checkOutput("post_vl", vl, 32'd32);
        checkOutput("post_vlmax", vlmax, 32'd32);
        checkOutput("post_vstart", vstart, 32'd0);
        checkOutput("post_res_valid", 32'(res_valid), 32'd0);

        applyStimulus(1'b0, '0, '0, 2'd0, 12'h009, 1'b1, 32'd0, 1'b1);
        readCsr(12'h009, 32'd1, "vxsat_sticky");
        applyStimulus(1'b0, '0, '0, 2'd0, 12'h00F, 1'b1, 32'h0000_0005, 1'b0);
        readCsr(12'h00A, 32'd2, "vcsr_vxrm");
        readCsr(12'h00F, 32'd5, "vcsr_read");
        applyStimulus(1'b0, '0, '0, 2'd0, 12'h008, 1'b1, 32'h0000_01FF, 1'b0);
        readCsr(12'h008, 32'h7F, "vstart_trunc");
        readCsr(12'hC22, 32'd16, "vlenb");
        csr_addr = 12'hC20; csr_we = 1'b1; csr_wdata = 32'd5;
        #1;
        checkOutput("wr_vl_illegal", 32'(csr_illegal), 32'd1);
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        checkOutput("vl_after_illegal_wr", vl, 32'd32);

        applyStimulus(1'b1, 32'd5, 32'h0000_0018, 2'd0, 12'hC20, 1'b0, '0, 1'b0);
        idle(2);
        checkOutput("vsew3_vill", 32'(vill), 32'd1);
        checkOutput("vsew3_vl", vl, 32'd0);
        checkOutput("vsew3_vlmax", vlmax, 32'd0);
        readCsr(12'hC21, 32'h8000_0000, "vsew3_vtype");

`ifdef IBEX_VEC_FRAC_LMUL_EN
        applyStimulus(1'b1, 32'd5, 32'h0000_0015, 2'd0, 12'hC20, 1'b0, '0, 1'b0);
        idle(2);
        checkOutput("frac_sew32_vill", 32'(vill), 32'd1);
        applyStimulus(1'b1, 32'd3, 32'h0000_0007, 2'd0, 12'hC20, 1'b0, '0, 1'b0);
        idle(2);
        checkOutput("frac_half_vill", 32'(vill), 32'd0);
        checkOutput("frac_half_vl", vl, 32'd3);
        checkOutput("frac_half_vlmax", vlmax, 32'd8);
`else
        applyStimulus(1'b1, 32'd3, 32'h0000_0007, 2'd0, 12'hC20, 1'b0, '0, 1'b0);
        idle(2);
        checkOutput("nofrac_vill", 32'(vill), 32'd1);
`endif

        // back-to-back requests held valid; the model tracks which ones are accepted
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 32'(i + 3), 32'h0000_0008 + 32'(i % 3), 2'(i % 3), 12'hC20, 1'b0, '0, 1'b0);
        end
        idle(3);

        applyStimulus(1'b1, 32'd100, 32'h0000_0001, 2'd1, 12'hC20, 1'b0, '0, 1'b0);
        idle(2);
        checkOutput("pre_abort_vl", vl, 32'd32);
        applyStimulus(1'b1, 32'd7, 32'h0000_0000, 2'd0, 12'hC20, 1'b0, '0, 1'b0);
        rstn = 1'b0;
        #1;
        checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cfg_valid = 1'b0;
        checkOutput("abort_vl", vl, 32'd0);
        checkOutput("abort_vill", 32'(vill), 32'd1);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] vt;
            logic [31:0] avl;
            case ($urandom_range(0, 9))
                0:       vt = $urandom;
                1:       vt = 32'h8000_0000 | 32'($urandom_range(0, 255));
                default: vt = 32'($urandom_range(0, 3)) << 6 | 32'($urandom_range(0, 3)) << 3 | 32'($urandom_range(0, 7));
            endcase
            avl = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70));
            applyStimulus(1'($urandom_range(0, 1)), avl, vt, 2'($urandom_range(0, 2)),
                          addr_pool[$urandom_range(0, 7)], $urandom_range(0, 3) == 0,
                          $urandom, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rstn = 1'b0;
                @(posedge clk);
                #1;
                rstn = 1'b1;
            end
        end
        idle(3);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
